fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are 2, 4 or 8.
REQ-002 SHALL have parameter HALT_OP, default 6'b111111, meaning the opcode value in instruction[15:10] that stops fetching.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 8 bits: instruction memory address, equal to the internal fetch PC.
REQ-006 SHALL have port imem_data, input, 16 bits: instruction word, valid combinationally in the same cycle as imem_addr.
REQ-007 SHALL have port jump, input, 1 bit: redirect request from the control unit.
REQ-008 SHALL have port jump_line, input, 8 bits: redirect target, sampled when jump=1.
REQ-009 SHALL have port instr_ready, input, 1 bit: control unit consumes the head entry.
REQ-010 SHALL have port instr_valid, output, 1 bit: head entry present.
REQ-011 SHALL have port instruction, output, 16 bits: head instruction word.
REQ-012 SHALL have port instr_pc, output, 8 bits: address the head instruction was fetched from.
REQ-013 SHALL have port fifo_count, output, 4 bits: number of occupied entries, 0..DEPTH.
REQ-014 SHALL have port stopped, output, 1 bit: 1 while in the STOPPED state.

Function
REQ-015 SHALL implement a two-state FSM, FETCH and STOPPED.
REQ-016 In FETCH with fifo_count<DEPTH and jump=0, SHALL push {imem_addr, imem_data} at the clock edge and increment the fetch PC by 1, mod 256 (255 wraps to 0).
REQ-017 With fifo_count==DEPTH, SHALL not push, even if a pop occurs in the same cycle.
REQ-018 SHALL pop the head on any edge where instr_valid=1 and instr_ready=1; instr_ready with instr_valid=0 SHALL have no effect.
REQ-019 A push and a pop in the same cycle SHALL leave fifo_count unchanged and preserve order.
REQ-020 instr_valid SHALL equal (fifo_count!=0); with the queue empty, instruction and instr_pc SHALL read 0.
REQ-021 Latency SHALL be one cycle: an entry pushed at edge N is visible at the head after edge N if the queue was empty.
REQ-022 When a pushed word has instruction[15:10]==HALT_OP, SHALL enqueue it and move to STOPPED at that edge, with the fetch PC left pointing to the halt address +1.
REQ-023 In STOPPED, SHALL perform no pushes; pops SHALL continue normally.
REQ-024 jump=1 SHALL take priority over push and pop: at that edge, flush all entries (fifo_count=0), load the fetch PC with jump_line, and enter FETCH from either state; no push SHALL occur that cycle.
REQ-025 A pop coinciding with jump SHALL count as consumed; the entry is discarded by the flush.
REQ-026 After a jump at edge N: imem_addr SHALL equal jump_line after edge N; the first new entry is pushed at edge N+1 and presented with instr_pc=jump_line after edge N+1.
REQ-027 Storage SHALL be a circular buffer with read and write pointers wrapping modulo DEPTH.

Reset
REQ-028 reset=1 at a clock edge SHALL set the fetch PC to 0, fifo_count to 0, both pointers to 0 and the state to FETCH.
REQ-029 During and after reset: imem_addr=0, instr_valid=0, instruction=0, instr_pc=0, fifo_count=0 and stopped=0.
REQ-030 reset SHALL override jump, push and pop in the same cycle, including when asserted mid-operation with the queue partly full.
REQ-031 After reset deasserts, the first push (address 0) SHALL occur at the next edge.

Verification
REQ-032 Reset release, instr_ready=0, imem returns 16'h1000+addr: after 4 edges, fifo_count=4 and the head is instr_pc=0 / 16'h1000; imem_addr stays 4 with no further pushes.
REQ-033 Full queue, instr_ready=1 for one cycle: fifo_count drops to 3, the head becomes pc 1; the push resumes on the following edge and fifo_count returns to 4.
REQ-034 Word 16'hFC00 at address 2 with instr_ready=1 continuously: entries 0,1,2 are delivered, stopped=1 after the push of address 2, and instr_valid=0 after pc 2 is consumed.
REQ-035 In STOPPED with 2 entries queued, jump=1, jump_line=8'hFE: fifo_count=0 and stopped=0 next cycle; pcs FE, FF, 00 are then delivered in order (wrap-around).
REQ-036 Queue holding 3 entries with jump and reset asserted together: all outputs match REQ-029 and imem_addr=0, not jump_line.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small in-order queue.
// The unit fetches one instruction word per cycle from a combinational instruction
// memory into a circular buffer. It stops fetching after it enqueues a halt opcode.
// A jump flushes the queue and redirects the fetch PC.
//
// Ports:
//   clk          - single clock, rising edge
//   reset        - synchronous active-high reset
//   imem_addr    - instruction memory address (the fetch PC)
//   imem_data    - instruction word for imem_addr, same cycle
//   jump         - redirect request; flushes the queue
//   jump_line    - redirect target address
//   instr_ready  - consumer takes the head entry
//   instr_valid  - head entry present
//   instruction  - head instruction word (0 when empty)
//   instr_pc     - address of head instruction (0 when empty)
//   fifo_count   - number of occupied entries
//   stopped      - fetching halted by a halt opcode
module fetch_queue #(
  parameter int          DEPTH   = 4,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        jump,
  input  logic [7:0]  jump_line,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [15:0] instruction,
  output logic [7:0]  instr_pc,
  output logic [3:0]  fifo_count,
  output logic        stopped
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic {
    FETCH   = 1'b0,
    STOPPED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      pc_q, pc_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [23:0]     mem_q [DEPTH];
  logic [23:0]     head_s;
  logic            push_s;
  logic            pop_s;
  logic            halt_s;

  // Next-state logic: jump outranks push/pop; a full queue never pushes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    push_s  = 1'b0;
    pop_s   = (cnt_q != 4'd0) && instr_ready;
    halt_s  = (imem_data[15:10] == HALT_OP);

    case (state_q)
      FETCH:   push_s = (cnt_q != DEPTH_C) && !jump;
      STOPPED: push_s = 1'b0;
      default: push_s = 1'b0;
    endcase

    if (jump) begin
      // A coinciding pop is considered consumed; the flush discards it.
      state_d = FETCH;
      pc_d    = jump_line;
      wr_d    = {AW{1'b0}};
      rd_d    = {AW{1'b0}};
      cnt_d   = 4'd0;
    end else begin
      if (push_s) begin
        wr_d = wr_q + AW'(1);
        pc_d = pc_q + 8'd1;
        if (halt_s) begin
          state_d = STOPPED;
        end else begin
          state_d = state_q;
        end
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = rd_q + AW'(1);
      end else begin
        rd_d = rd_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + 4'd1;
        2'b01:   cnt_d = cnt_q - 4'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= 8'd0;
      wr_q    <= {AW{1'b0}};
      rd_q    <= {AW{1'b0}};
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry storage; contents are only observable while counted as valid.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_q[wr_q] <= {pc_q, imem_data};
    end
  end

  assign head_s      = mem_q[rd_q];
  assign instr_valid = (cnt_q != 4'd0);
  assign instruction = instr_valid ? head_s[15:0]  : 16'h0000;
  assign instr_pc    = instr_valid ? head_s[23:16] : 8'h00;
  assign imem_addr   = pc_q;
  assign fifo_count  = cnt_q;
  assign stopped     = (state_q == STOPPED);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plus random bench for fetch_queue. It keeps a
// scoreboard queue of expected {pc, word} entries together with a small fetch
// model. It compares the head and the status outputs around every clock edge.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        jump;
  logic [7:0]  jump_line;
  logic        instr_ready;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [7:0]  instr_pc;
  logic [3:0]  fifo_count;
  logic        stopped;

  int checks = 0;
  int errors = 0;

  logic [8:0]  halt_addr;   // 9'h1FF means no halt word in memory
  logic [23:0] sb [$];      // expected entries, head first
  logic [7:0]  m_pc;
  logic        m_stop;

  fetch_queue #(.DEPTH(4), .HALT_OP(6'b111111)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .jump        (jump),
    .jump_line   (jump_line),
    .instr_ready (instr_ready),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .fifo_count  (fifo_count),
    .stopped     (stopped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data = ({1'b0, imem_addr} == halt_addr) ? 16'hFC00
                                                      : (16'h1000 + {8'h00, imem_addr});

  function automatic logic [15:0] mem_fn(input logic [7:0] a);
    if ({1'b0, a} == halt_addr) return 16'hFC00;
    return 16'h1000 + {8'h00, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check head before the edge, update model, check status after.
  task automatic step(input logic r, input logic j, input logic [7:0] jl, input logic rdy);
    logic [23:0] e;
    logic        do_push;
    logic [15:0] w;
    reset = r; jump = j; jump_line = jl; instr_ready = rdy;
    #2;
    if (sb.size() != 0) e = sb[0]; else e = 24'h0;
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, (sb.size() != 0)});
    chk("instruction", {16'd0, instruction}, {16'd0, e[15:0]});
    chk("instr_pc",    {24'd0, instr_pc},    {24'd0, e[23:16]});
    chk("imem_addr_pre", {24'd0, imem_addr}, {24'd0, m_pc});
    if (r) begin
      sb.delete(); m_pc = 8'h00; m_stop = 1'b0;
    end else if (j) begin
      sb.delete(); m_pc = jl; m_stop = 1'b0;
    end else begin
      do_push = !m_stop && (sb.size() < 4);
      w = mem_fn(m_pc);
      if (rdy && sb.size() != 0) void'(sb.pop_front());
      if (do_push) begin
        sb.push_back({m_pc, w});
        m_pc = m_pc + 8'd1;
        if (w[15:10] == 6'b111111) m_stop = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("fifo_count", {28'd0, fifo_count}, sb.size());
    chk("imem_addr",  {24'd0, imem_addr},  {24'd0, m_pc});
    chk("stopped",    {31'd0, stopped},    {31'd0, m_stop});
  endtask

  initial begin
    reset = 1'b1; jump = 1'b0; jump_line = 8'h00; instr_ready = 1'b0;
    halt_addr = 9'h1FF; m_pc = 8'h00; m_stop = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("reset_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset_addr",  {24'd0, imem_addr},   32'd0);

    // Fill with no consumer; the queue must stop at 4 with PC held at 4.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("fill_count", {28'd0, fifo_count}, 32'd4);
    chk("fill_pc",    {24'd0, instr_pc},   32'd0);
    chk("fill_instr", {16'd0, instruction}, 32'h1000);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("full_addr", {24'd0, imem_addr}, 32'd4);

    // Pop on a full queue: no push that edge, resume on the next one.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("popfull_count", {28'd0, fifo_count}, 32'd3);
    chk("popfull_pc",    {24'd0, instr_pc},   32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("refill_count", {28'd0, fifo_count}, 32'd4);

    // Halt word at address 2 with a continuous consumer.
    halt_addr = 9'h002;
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("halt_stopped", {31'd0, stopped}, 32'd1);
    chk("halt_addr",    {24'd0, imem_addr}, 32'd3);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("halt_drained", {31'd0, instr_valid}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Stopped with two entries queued, then jump to FE (pop coincides).
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pre_jump_count", {28'd0, fifo_count}, 32'd2);
    chk("pre_jump_stop",  {31'd0, stopped},    32'd1);
    halt_addr = 9'h1FF;
    step(1'b0, 1'b1, 8'hFE, 1'b1);
    chk("jump_count", {28'd0, fifo_count}, 32'd0);
    chk("jump_stop",  {31'd0, stopped},    32'd0);
    chk("jump_addr",  {24'd0, imem_addr},  32'hFE);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("jump_first_pc", {24'd0, instr_pc}, 32'hFE);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset and jump together with three entries queued.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b1);
    chk("rstjump_addr",  {24'd0, imem_addr},   32'd0);
    chk("rstjump_count", {28'd0, fifo_count},  32'd0);
    chk("rstjump_valid", {31'd0, instr_valid}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("post_reset_pc", {24'd0, instr_pc}, 32'd0);

    // Random consumer with occasional jumps and halts.
    halt_addr = 9'h0A3;
    for (int i = 0; i < 120; i++) begin
      logic j;
      logic [7:0] t;
      j = ($urandom_range(0, 15) == 0);
      t = 8'($urandom_range(160, 175));
      step(1'b0, j, t, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
